cla_slice_sequencer: RTL and testbench



---
 rtl/cla_slice_sequencer.sv | 123 ++++++++++++
 tb/tb_cla_slice_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead slice per clock.
// Optional macro SLICE_SUB_EN enables op_sub (B inversion, carry-in 1); otherwise add-only.
module cla_slice_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, b_q, b_eff;
    logic               carry_q, carry_init;
    logic [CW-1:0]      cnt;
    logic [CW+1:0]      base;
    logic               accept, last;
    logic [SLICE-1:0]   nib_a, nib_b, nib_g, nib_p, nib_sum;
    logic [SLICE:0]     nib_c;

`ifdef SLICE_SUB_EN
    assign b_eff      = op_sub ? ~b : b;
    assign carry_init = op_sub;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign b_eff         = b;
    assign carry_init    = 1'b0;
`endif

    // Slice is fixed at 4 bits, so the nibble base is cnt*4.
    assign base  = {cnt, 2'b00};
    assign nib_a = a_q[base +: SLICE];
    assign nib_b = b_q[base +: SLICE];
    assign nib_g = nib_a & nib_b;
    assign nib_p = nib_a ^ nib_b;

    assign nib_c[0] = carry_q;
    assign nib_c[1] = nib_g[0] | (nib_p[0] & carry_q);
    assign nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry_q);
    assign nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
                    | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
    assign nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
                    | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                    | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
    assign nib_sum  = nib_p ^ nib_c[3:0];

    assign last = (cnt == CW'(NSLICE - 1));
    assign zero = (sum == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                // A start seen in DONE chains straight into the next operation.
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= carry_init;
            cnt     <= '0;
        end else if (state == RUN) begin
            sum[base +: SLICE] <= nib_sum;
            carry_q            <= nib_c[SLICE];
            cnt                <= cnt + 1'b1;
            if (last) begin
                cout <= nib_c[SLICE];
                ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (nib_sum[SLICE-1] != a_q[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops and compares on every done.
module tb_cla_slice_sequencer;
    localparam int WIDTH  = 32;
    localparam int NSLICE = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             op_sub = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             busy, done, cout, ovf, zero;
    logic [WIDTH-1:0] sum;

    cla_slice_sequencer #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain wide-integer arithmetic on the operands.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s, input int c);
        exp_t        e;
        logic [32:0] full;
        logic [31:0] ye;
        logic        cin;
`ifdef SLICE_SUB_EN
        ye  = s ? ~y : y;
        cin = s;
`else
        ye  = y;
        cin = s & 1'b0;
`endif
        full   = {1'b0, x} + {1'b0, ye} + {32'd0, cin};
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = (x[31] == ye[31]) && (full[31] != x[31]);
        e.cyc  = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 64'(sum), 64'(e.sum));
                chk("cout", 64'(cout), 64'(e.cout));
                chk("ovf", 64'(ovf), 64'(e.ovf));
                chk("zero", 64'(zero), 64'(e.sum == 32'd0));
                chk("busy_at_done", 64'(busy), 64'd0);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 80) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d results pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        int c0;
        @(negedge clk);
        start = 1'b1; a = x; b = y; op_sub = s;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
        sb.push_back(model(x, y, s, c0 + NSLICE));
        chk("busy_run", 64'(busy), 64'd1);
        drain();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_sum"}, 64'(sum), 64'd0);
        chk({tag, "_zero"}, 64'(zero), 64'd1);
        chk({tag, "_cout"}, 64'(cout), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    endtask

    initial begin
        #3;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("idle");

        // Directed vectors
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1);

        // Busy protection: restarts during RUN with new operands are dropped
        begin
            int c0;
            @(negedge clk);
            start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; op_sub = 1'b0;
            @(negedge clk);
            c0 = cyc;
            sb.push_back(model(32'h1234_5678, 32'h1111_1111, 1'b0, c0 + NSLICE));
            a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op_sub = 1'b1;
            repeat (4) @(negedge clk);
            start = 1'b0;
            drain();
            repeat (12) @(negedge clk);
        end

        // Back-to-back with start held: three operations, one every NSLICE+1 cycles
        begin
            int c0;
            @(negedge clk);
            start = 1'b1; a = 32'h8000_0000; b = 32'h8000_0000; op_sub = 1'b0;
            @(negedge clk);
            c0 = cyc;
            for (int k = 0; k < 3; k++)
                sb.push_back(model(32'h8000_0000, 32'h8000_0000, 1'b0, c0 + NSLICE + k * (NSLICE + 1)));
            while (cyc < c0 + 2 * (NSLICE + 1)) @(negedge clk);
            start = 1'b0;
            drain();
        end

        // Reset mid-operation: no done may follow
        begin
            @(negedge clk);
            start = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0001; op_sub = 1'b0;
            @(negedge clk);
            start = 1'b0;
            sb.push_back(model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, cyc + NSLICE));
            repeat (3) @(negedge clk);
            #2;
            rst = 1'b1;
            sb.delete();
            #1;
            check_reset_state("midrun_reset");
            @(negedge clk);
            rst = 1'b0;
            repeat (15) @(negedge clk);
            chk("post_reset_busy", 64'(busy), 64'd0);
        end

        // Randomized operations with random idle gaps
        for (int i = 0; i < 30; i++) begin
            logic [31:0] x, y;
            logic        s;
            x = $urandom;
            y = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i % 5 == 0) y = ~x;
            run_op(x, y, s);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
